riscv_multicycle_control: RTL

- Multi-cycle successor to the single-cycle main decoder for the RV32I datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over several cycles, sharing one ALU and one unified memory port.
- Supports variable-latency memory through a ready handshake, covers a wider opcode set (adds JAL, JALR, LUI, AUIPC), and traps on illegal opcodes or memory timeout.
- Sits between the instruction register and the multi-cycle datapath muxes and enables.

---
 rtl/riscv_multicycle_control.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle main control FSM for the RV32I datapath.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, sharing one
// ALU and one unified memory port. It waits on a memory ready handshake,
// and traps on an illegal opcode or on a memory access that times out.
module riscv_multicycle_control #(
  parameter int MEM_TIMEOUT = 15,  // max wait cycles per memory access, 0 = no timeout
  parameter int CNT_W       = 4    // wait counter width, 2**CNT_W > MEM_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       branch_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] mem_to_reg_o,
  output logic       instr_retire_o,
  output logic       illegal_o,
  output logic [2:0] state_o
);

  // Encodings are visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  // Instruction class. It is latched in DECODE so that the later states
  // do not depend on instr_op_i staying stable.
  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_NONE
  } instr_class_t;

  // ALU operand and operation codes shared with the datapath.
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcARs1   = 2'b01;
  localparam logic [1:0] SrcAOldPc = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluBranch = 2'b01;
  localparam logic [1:0] AluRFunct = 2'b10;
  localparam logic [1:0] AluIFunct = 2'b11;
  localparam logic [1:0] PcAluRes  = 2'b00;
  localparam logic [1:0] PcAluOut  = 2'b01;
  localparam logic [1:0] WbAluOut  = 2'b00;
  localparam logic [1:0] WbMdr     = 2'b01;
  localparam logic [1:0] WbLink    = 2'b10;

  localparam bit              TimeoutEnabled = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TimeoutCount  = CNT_W'(MEM_TIMEOUT);

  state_t             state;
  instr_class_t       instrClass;
  logic [CNT_W-1:0]   waitCnt;
  logic               memWait;
  logic               timedOut;

  // Map an opcode to its class. An unknown opcode maps to CLS_NONE and traps.
  function automatic instr_class_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return CLS_R;
      7'b0010011: return CLS_I;
      7'b0000011: return CLS_LOAD;
      7'b0100011: return CLS_STORE;
      7'b1100011: return CLS_BRANCH;
      7'b1101111: return CLS_JAL;
      7'b1100111: return CLS_JALR;
      7'b0110111: return CLS_LUI;
      7'b0010111: return CLS_AUIPC;
      default:    return CLS_NONE;
    endcase
  endfunction

  // Detect a stalled memory access, and whether this cycle is its last allowed wait.
  always_comb begin
    memWait  = ((state == FETCH) || (state == MEM)) && !mem_ready_i;
    // When mem_ready_i arrives in the same cycle as the limit, the access
    // completes normally: memWait is low, so there is no timeout.
    timedOut = TimeoutEnabled && memWait && (waitCnt == TimeoutCount);
  end

  // State, latched instruction class and saturating wait counter.
  always_ff @(posedge clk_i) begin
    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples the values from before the edge no matter the statement order.
    if (rst_i) begin
      state      <= FETCH;
      instrClass <= CLS_NONE;
      waitCnt    <= '0;
    end else begin
      // The counter counts only while an access stalls. Every other cycle
      // clears it, so it always starts at 0 on entry to FETCH or MEM.
      if (memWait && !timedOut) begin
        if (waitCnt != '1) waitCnt <= waitCnt + 1'b1;
      end else begin
        waitCnt <= '0;
      end

      case (state)
        FETCH: begin
          if (mem_ready_i)   state <= DECODE;
          else if (timedOut) state <= TRAP;
        end
        DECODE: begin
          instrClass <= classify(instr_op_i);
          state      <= (classify(instr_op_i) == CLS_NONE) ? TRAP : EXEC;
        end
        EXEC: begin
          case (instrClass)
            CLS_LOAD, CLS_STORE: state <= MEM;
            CLS_BRANCH:          state <= FETCH;
            CLS_NONE:            state <= TRAP;
            default:             state <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready_i)   state <= (instrClass == CLS_LOAD) ? WB : FETCH;
          else if (timedOut) state <= TRAP;
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  // Drive the datapath controls from state, the latched class and mem_ready_i. All are forced to 0 during reset.
  always_comb begin
    // NOTE: every output gets a default before the case, so a path that
    // skips an assignment cannot infer a latch.
    pc_write_o     = 1'b0;
    branch_o       = 1'b0;
    ir_write_o     = 1'b0;
    iord_o         = 1'b0;
    mem_read_o     = 1'b0;
    mem_write_o    = 1'b0;
    reg_write_o    = 1'b0;
    alu_src_a_o    = SrcAPc;
    alu_src_b_o    = SrcBRs2;
    alu_op_o       = AluAdd;
    pc_src_o       = PcAluRes;
    mem_to_reg_o   = WbAluOut;
    instr_retire_o = 1'b0;
    illegal_o      = 1'b0;
    state_o        = 3'd0;

    if (!rst_i) begin
      state_o = state;
      case (state)
        FETCH: begin
          // Read the instruction at PC, and compute PC+4 on the ALU at the same time.
          mem_read_o  = 1'b1;
          alu_src_a_o = SrcAPc;
          alu_src_b_o = SrcBFour;
          alu_op_o    = AluAdd;
          pc_src_o    = PcAluRes;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        DECODE: begin
          // Precompute the branch/JAL target oldPC+imm into ALUOut.
          alu_src_a_o = SrcAOldPc;
          alu_src_b_o = SrcBImm;
          alu_op_o    = AluAdd;
        end
        EXEC: begin
          case (instrClass)
            CLS_R: begin
              alu_src_a_o = SrcARs1;
              alu_src_b_o = SrcBRs2;
              alu_op_o    = AluRFunct;
            end
            CLS_I: begin
              alu_src_a_o = SrcARs1;
              alu_src_b_o = SrcBImm;
              alu_op_o    = AluIFunct;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_src_a_o = SrcARs1;
              alu_src_b_o = SrcBImm;
              alu_op_o    = AluAdd;
            end
            CLS_BRANCH: begin
              // The ALU compares rs1 and rs2. The datapath qualifies the PC
              // write with the taken flag and uses the target from DECODE.
              alu_src_a_o    = SrcARs1;
              alu_src_b_o    = SrcBRs2;
              alu_op_o       = AluBranch;
              branch_o       = 1'b1;
              pc_src_o       = PcAluOut;
              instr_retire_o = 1'b1;
            end
            CLS_JAL: begin
              pc_write_o = 1'b1;
              pc_src_o   = PcAluOut;
            end
            CLS_JALR: begin
              alu_src_a_o = SrcARs1;
              alu_src_b_o = SrcBImm;
              alu_op_o    = AluAdd;
              pc_write_o  = 1'b1;
              pc_src_o    = PcAluRes;
            end
            CLS_LUI: begin
              alu_src_a_o = SrcAZero;
              alu_src_b_o = SrcBImm;
              alu_op_o    = AluAdd;
            end
            CLS_AUIPC: begin
              alu_src_a_o = SrcAOldPc;
              alu_src_b_o = SrcBImm;
              alu_op_o    = AluAdd;
            end
            default: ;
          endcase
        end
        MEM: begin
          // The request is held until memory reports ready.
          iord_o         = 1'b1;
          mem_read_o     = (instrClass == CLS_LOAD);
          mem_write_o    = (instrClass == CLS_STORE);
          instr_retire_o = (instrClass == CLS_STORE) && mem_ready_i;
        end
        WB: begin
          reg_write_o    = 1'b1;
          instr_retire_o = 1'b1;
          case (instrClass)
            CLS_LOAD:          mem_to_reg_o = WbMdr;
            CLS_JAL, CLS_JALR: mem_to_reg_o = WbLink;
            default:           mem_to_reg_o = WbAluOut;
          endcase
        end
        TRAP: illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
